cpu_control_unit: RTL
=====================

# cpu_control_unit

Multi-cycle control unit for the 8-bit custom-ISA processor. Fetches 16-bit instructions from instruction memory over a request/acknowledge handshake and decodes them. Sequences the 4-bit-opcode ALU and the external 4x8 register file through a FETCH/DECODE/EXECUTE/WRITEBACK state machine. Owns the program counter and the architectural Z/C flag register, and resolves conditional branches.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  leaves IDLE when sampled 1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  8  fetch address; equals PC.
- `imem_ack`  in  1  memory has valid `imem_data` this cycle.
- `imem_data`  in  16  instruction word.
- `alu_op`  out  4  ALU opcode.
- `alu_zero`  in  1  ALU zero flag.
- `alu_carry`  in  1  ALU carry flag.
- `rf_ra`  out  2  register-file read port A select (rs1).
- `rf_rb`  out  2  register-file read port B select (rs2).
- `rf_wa`  out  2  write select (rd).
- `rf_we`  out  1  write enable, one-cycle pulse.
- `rf_wsrc`  out  1  0 = write ALU result, 1 = write `imm`.
- `imm`  out  8  immediate field of the current instruction.
- `flag_z`  out  1  architectural zero flag.
- `flag_c`  out  1  architectural carry flag.
- `halted`  out  1  in HALT state.
- `illegal`  out  1  sticky; set when an undefined opcode is decoded.

## Operation
- Instruction fields: [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (rs2 and imm overlap; each opcode uses only one of them).
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT rs1, 0110 INC rs1, 0111 DEC rs1: `alu_op` = opcode[3:0], result written to rd.
  - 1000 LDI: rd <= imm. Flags are unchanged.
  - 1001 JMP: PC <= imm.
  - 1010 JZ: PC <= imm if `flag_z`, else PC+1.
  - 1011 JC: PC <= imm if `flag_c`, else PC+1.
  - 1100 NOP.
  - 1111 HLT.
  - 1101 and 1110 are illegal: set `illegal` and go to HALT.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
  - IDLE -> FETCH when `run`=1.
  - FETCH -> DECODE on `imem_ack`; the instruction register latches `imem_data` in the same cycle.
  - DECODE -> HALT on HLT or an illegal opcode; otherwise DECODE -> EXECUTE.
  - EXECUTE -> WRITEBACK for ALU ops and LDI; otherwise EXECUTE -> FETCH.
  - WRITEBACK -> FETCH.
  - HALT is terminal until reset.
- ALU ops:
  - `rf_ra`/`rf_rb`/`alu_op` are driven from DECODE through WRITEBACK.
  - In WRITEBACK: `rf_we`=1, `rf_wsrc`=0, and `flag_z`/`flag_c` latch `alu_zero`/`alu_carry`.
- LDI: in WRITEBACK, `rf_we`=1 and `rf_wsrc`=1.
- PC update:
  - Non-jump instructions: PC <= PC+1 in EXECUTE.
  - Jumps: target resolved in EXECUTE using flag values as they stand at EXECUTE entry.
  - Increment is modulo 256: 8'hFF wraps to 8'h00.
- `run` is sampled only in IDLE; deasserting it later has no effect.

## Timing
- Reset values:
  - state IDLE; PC = `RESET_PC`.
  - `imem_req`, `rf_we`, `flag_z`, `flag_c`, `halted`, `illegal` = 0.
  - `alu_op`, `rf_ra`, `rf_rb`, `rf_wa`, `imm` = 0; `rf_wsrc` = 0.
- Instruction latency with zero-wait memory (ack in the first FETCH cycle):
  - ALU op / LDI: 4 cycles.
  - JMP/JZ/JC/NOP: 3 cycles.
  - Each FETCH cycle without ack adds one cycle.
- Fetch handshake:
  - `imem_req`=1 is asserted and `imem_addr` held stable for every FETCH cycle until `imem_ack` is sampled 1.
  - `imem_req` drops in the cycle after acceptance.
  - `imem_ack` while `imem_req`=0 is ignored.
- `rf_we` is high for exactly one cycle per ALU/LDI instruction and never in any other state.
- `halted` goes high the cycle after DECODE of HLT or an illegal opcode.
- Reset mid-instruction (any state): all outputs take their reset values immediately (asynchronous). A pending write is dropped; a pending fetch is abandoned.

## Structure
- Package `cpu_pkg` holds:
  - `opcode_e` (4-bit opcode enum) and `ctrl_state_e`.
  - Field bit-position localparams.
- Sub-module `instr_decoder`: purely combinational; opcode -> {is_alu, is_ldi, is_jmp, jmp_cond, is_halt, is_illegal}.
- The top holds the FSM, PC, instruction register and flag register.

## Test plan
- Reset, `run`=1, program at 0x00 {LDI r0,100; LDI r1,120; ADD r2,r0,r1}:
  - r2 write of 220 with `flag_z`=0, `flag_c`=0.
  - Each instruction completes in its stated cycle count.
- {LDI r0,50; LDI r1,100; SUB r2,r0,r1}: write of 206 with `flag_c`=1.
- SUB 10-10 then JZ 0x40: PC=0x40 (branch taken). Repeat with SUB 10-9: PC = branch address + 1 (not taken).
- `imem_ack` held low 3 cycles in FETCH:
  - `imem_req` and `imem_addr` remain stable throughout.
  - Instruction latches on the ack cycle; total latency +3.
- Opcode 1101 at PC=0x05:
  - `illegal`=1 and `halted`=1.
  - No further `imem_req`.
  - PC stays 0x05.
- Two cases:
  - Assert `rst_n`=0 during WRITEBACK: `rf_we` drops immediately, flags=0, PC=`RESET_PC`.
  - NOP at 0xFF: next fetch address 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU control path: opcodes, controller states,
// jump conditions and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_INC = 4'h6,
    OP_DEC = 4'h7,
    OP_LDI = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_JC  = 4'hB,
    OP_NOP = 4'hC,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    JC_ALWAYS,
    JC_ZERO,
    JC_CARRY
  } jmp_cond_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier; 1101 and 1110 fall through to illegal.
module instr_decoder
  import cpu_pkg::*;
(
  input  opcode_e   opcode,
  output logic      is_alu,
  output logic      is_ldi,
  output logic      is_jmp,
  output jmp_cond_e jmp_cond,
  output logic      is_halt,
  output logic      is_illegal
);

  always_comb begin
    is_alu     = 1'b0;
    is_ldi     = 1'b0;
    is_jmp     = 1'b0;
    jmp_cond   = JC_ALWAYS;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_INC, OP_DEC: is_alu = 1'b1;
      OP_LDI: is_ldi = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      OP_JZ: begin
        is_jmp   = 1'b1;
        jmp_cond = JC_ZERO;
      end
      OP_JC: begin
        is_jmp   = 1'b1;
        jmp_cond = JC_CARRY;
      end
      OP_NOP: ;
      OP_HLT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller owning PC, instruction
// register and the Z/C flags; ALU and register file live outside.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  alu_op,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [1:0]  rf_ra,
  output logic [1:0]  rf_rb,
  output logic [1:0]  rf_wa,
  output logic        rf_we,
  output logic        rf_wsrc,
  output logic [7:0]  imm,
  output logic        flag_z,
  output logic        flag_c,
  output logic        halted,
  output logic        illegal
);

  ctrl_state_e state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;
  logic        illegal_q, illegal_d;

  logic        is_alu, is_ldi, is_jmp, is_halt, is_illegal;
  jmp_cond_e   jmp_cond;
  logic        jmp_taken;

  instr_decoder u_decoder (
    .opcode     (opcode_e'(ir_q[OPC_MSB:OPC_LSB])),
    .is_alu     (is_alu),
    .is_ldi     (is_ldi),
    .is_jmp     (is_jmp),
    .jmp_cond   (jmp_cond),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      illegal_q <= illegal_d;
    end
  end

  // Branches use the flags held in the register, i.e. as they stood at EXECUTE entry.
  always_comb begin
    case (jmp_cond)
      JC_ALWAYS: jmp_taken = 1'b1;
      JC_ZERO:   jmp_taken = flag_z_q;
      JC_CARRY:  jmp_taken = flag_c_q;
      default:   jmp_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_illegal) illegal_d = 1'b1;
        state_d = (is_halt || is_illegal) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        pc_d    = (is_jmp && jmp_taken) ? ir_q[IMM_MSB:IMM_LSB] : pc_q + 8'd1;
        state_d = (is_alu || is_ldi) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: begin
        if (is_alu) begin
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    logic in_exec;
    in_exec   = (state_q == ST_DECODE) || (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
    imem_req  = (state_q == ST_FETCH);
    imem_addr = pc_q;
    alu_op    = in_exec ? ir_q[OPC_MSB:OPC_LSB] : 4'd0;
    rf_ra     = in_exec ? ir_q[RS1_MSB:RS1_LSB] : 2'd0;
    rf_rb     = in_exec ? ir_q[RS2_MSB:RS2_LSB] : 2'd0;
    rf_wa     = ir_q[RD_MSB:RD_LSB];
    imm       = ir_q[IMM_MSB:IMM_LSB];
    rf_we     = (state_q == ST_WRITEBACK);
    rf_wsrc   = (state_q == ST_WRITEBACK) && is_ldi;
    flag_z    = flag_z_q;
    flag_c    = flag_c_q;
    halted    = (state_q == ST_HALT);
    illegal   = illegal_q;
  end

endmodule
